// File: rtl/oddr_2.sv
// oddr_2: single-clock DDR output register; rising edge = phase 0, falling edge = phase 1.
// Define ODDR_ALIGN_EN to compile in the "C0"/"C1" capture alignment modes.
module oddr_2 #(
    parameter logic  INIT          = 1'b0,
    parameter string DDR_ALIGNMENT = "NONE"
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic set_in,
    input  logic ce_in,
    input  logic d0_in,
    input  logic d1_in,
    output logic q_out
);

    logic r0_q = INIT;
    logic r1_q = INIT;
    logic r0_d;
    logic r1_d;
    logic src0;
    logic src1;

`ifdef ODDR_ALIGN_EN
    localparam bit ALIGN_C0 = (DDR_ALIGNMENT == "C0");
    localparam bit ALIGN_C1 = (DDR_ALIGNMENT == "C1");

    // Other-phase data held from the shared capture edge until its own edge.
    logic cap_q = INIT;
    logic cap_d;

    always_comb begin
        cap_d = cap_q;
        if (reset_in)
            cap_d = 1'b0;
        else if (set_in)
            cap_d = 1'b1;
        else if (ce_in)
            cap_d = ALIGN_C1 ? d0_in : d1_in;
    end

    generate
        if (ALIGN_C1) begin : g_cap_fall
            always_ff @(negedge clk_in) cap_q <= cap_d;
        end else begin : g_cap_rise
            always_ff @(posedge clk_in) cap_q <= cap_d;
        end
    endgenerate

    assign src0 = ALIGN_C1 ? cap_q : d0_in;
    assign src1 = ALIGN_C0 ? cap_q : d1_in;
`else
    // Alignment modes are not built; every DDR_ALIGNMENT value acts as "NONE".
    generate
        if (DDR_ALIGNMENT != "NONE") begin : g_align_as_none
        end
    endgenerate

    assign src0 = d0_in;
    assign src1 = d1_in;
`endif

    always_comb begin
        r0_d = r0_q;
        if (reset_in)
            r0_d = 1'b0;
        else if (set_in)
            r0_d = 1'b1;
        else if (ce_in)
            r0_d = src0;
    end

    always_comb begin
        r1_d = r1_q;
        if (reset_in)
            r1_d = 1'b0;
        else if (set_in)
            r1_d = 1'b1;
        else if (ce_in)
            r1_d = src1;
    end

    always_ff @(posedge clk_in) begin
        r0_q <= r0_d;
    end

    always_ff @(negedge clk_in) begin
        r1_q <= r1_d;
    end

    assign q_out = clk_in ? r0_q : r1_q;

endmodule

// File: tb/tb_oddr_2.sv
// tb_oddr_2: table-driven and randomized checks of oddr_2 against a half-cycle model.
// With ODDR_ALIGN_EN defined, a "C0" instance is also exercised.
module tb_oddr_2;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b0;
    logic set_in   = 1'b0;
    logic ce_in    = 1'b0;
    logic d0_in    = 1'b0;
    logic d1_in    = 1'b0;
    logic q_out;
    logic q_i1;

    int checks   = 0;
    int failures = 0;

    // Model of the two phase values, updated per edge from the priority rules.
    logic m0 = 1'b0;
    logic m1 = 1'b0;

    typedef struct {
        logic r;
        logic s;
        logic c;
        logic a;
        logic b;
        logic e;
    } vec_t;

    vec_t tbl[$];

    oddr_2 #(.INIT(1'b0), .DDR_ALIGNMENT("NONE")) dut (
        .clk_in(clk_in), .reset_in(reset_in), .set_in(set_in),
        .ce_in(ce_in), .d0_in(d0_in), .d1_in(d1_in), .q_out(q_out)
    );

    oddr_2 #(.INIT(1'b1), .DDR_ALIGNMENT("NONE")) u_i1 (
        .clk_in(clk_in), .reset_in(reset_in), .set_in(set_in),
        .ce_in(ce_in), .d0_in(d0_in), .d1_in(d1_in), .q_out(q_i1)
    );

`ifdef ODDR_ALIGN_EN
    logic q_c0;
    oddr_2 #(.INIT(1'b0), .DDR_ALIGNMENT("C0")) u_c0 (
        .clk_in(clk_in), .reset_in(reset_in), .set_in(set_in),
        .ce_in(ce_in), .d0_in(d0_in), .d1_in(d1_in), .q_out(q_c0)
    );
`endif

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic nxt(logic m, logic r, logic s, logic c, logic d);
        if (r) return 1'b0;
        if (s) return 1'b1;
        if (c) return d;
        return m;
    endfunction

    task automatic check(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b t=%0t", name, got, want, $time);
        end
    endtask

    function automatic void add(logic r, logic s, logic c, logic a, logic b, logic e);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.a = a; v.b = b; v.e = e;
        tbl.push_back(v);
    endfunction

    // Drive inputs, take the next edge, then compare q_out against the model.
    task automatic step(input logic r, input logic s, input logic c,
                        input logic a, input logic b, output logic got);
        reset_in = r; set_in = s; ce_in = c; d0_in = a; d1_in = b;
        @(clk_in);
        if (clk_in) m0 = nxt(m0, r, s, c, a);
        else        m1 = nxt(m1, r, s, c, b);
        #1;
        got = q_out;
        check("model", got, clk_in ? m0 : m1);
    endtask

    initial begin
        logic got;

        // Entries alternate rising/falling edges, starting with a rising edge.
        for (int i = 0; i < 4; i++) add(1, 0, 1, 1, 1, 0);
        add(0, 0, 1, 1, 1, 1); add(0, 0, 1, 1, 1, 1);
        add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 1, 0, 0);
        add(1, 1, 1, 1, 0, 0); add(1, 1, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 1); add(0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 1);
        add(0, 0, 1, 1, 1, 1); add(0, 0, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0); add(0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1);

        #1;
        check("powerup_init0", q_out, 1'b0);
        check("powerup_init1", q_i1, 1'b1);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].a, tbl[i].b, got);
            check($sformatf("vec%0d", i), got, tbl[i].e);
        end

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(7) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(3) != 0), 1'($urandom), 1'($urandom), got);
        end

`ifdef ODDR_ALIGN_EN
        @(negedge clk_in);
        #1;
        reset_in = 0; set_in = 0; ce_in = 1; d0_in = 0; d1_in = 1;
        @(posedge clk_in);
        #1;
        d1_in = 0;
        @(negedge clk_in);
        #1;
        check("c0_low_phase", q_c0, 1'b1);
        check("none_low_phase", q_out, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
